// File: rtl/amm_slave_mem_pkg.sv
// -----------------------------------------------------------------------------
// amm_slave_mem_pkg
// Shared settings for the Avalon-MM burst responder (amm_slave_mem):
//   - default bus geometry for the AMM slave
//   - slave_state_t: burst FSM state encoding
// -----------------------------------------------------------------------------
package amm_slave_mem_pkg;

    localparam int SLAVE_AMM_ADDR_W  = 32;
    localparam int SLAVE_AMM_DATA_W  = 512;
    localparam int SLAVE_AMM_BURST_W = 11;
    localparam int SLAVE_MEM_WORDS_W = 8;
    localparam int SLAVE_RD_LAT      = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WR_BURST = 2'b01,
        RD_BURST = 2'b10
    } slave_state_t;

endpackage

// File: rtl/amm_slave_ram.sv
// -----------------------------------------------------------------------------
// amm_slave_ram
// Simple dual-port RAM with per-byte write enables and a registered read
// pipeline of RD_LAT stages (data + valid). Write-first on a same-cycle
// collision. Contents are not reset; only the read pipeline is.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (read pipeline only)
//   i_wr_en          write strobe
//   i_wr_idx         write word index
//   i_wr_data        write data
//   i_wr_be          per-byte write enable
//   i_rd_en          read issue strobe
//   i_rd_idx         read word index
//   i_rd_inv0        invert byte 0 of the word being issued
//   o_rd_data        read data, RD_LAT cycles after issue
//   o_rd_valid       read data valid
// -----------------------------------------------------------------------------
module amm_slave_ram #(
    parameter int DATA_W  = 512,
    parameter int WORDS_W = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [WORDS_W-1:0]    i_wr_idx,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    input  logic                  i_rd_en,
    input  logic [WORDS_W-1:0]    i_rd_idx,
    input  logic                  i_rd_inv0,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid
);

    localparam int DATA_B_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem  [2**WORDS_W];
    logic [DATA_W-1:0] r_data [RD_LAT];
    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] w_rd_word;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int unsigned b = 0; b < DATA_B_W; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Merge an in-flight write to the same word so the read sees new data.
    always_comb begin
        w_rd_word = r_mem[i_rd_idx];
        if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
            for (int unsigned b = 0; b < DATA_B_W; b++) begin
                if (i_wr_be[b]) begin
                    w_rd_word[b*8 +: 8] = i_wr_data[b*8 +: 8];
                end
            end
        end
        if (i_rd_inv0) begin
            w_rd_word[7:0] = ~w_rd_word[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_rd_en;
            if (i_rd_en) begin
                r_data[0] <= w_rd_word;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_rd_data  = r_data[RD_LAT-1];
    assign o_rd_valid = r_vld[RD_LAT-1];

endmodule

// File: rtl/amm_slave_mem.sv
// -----------------------------------------------------------------------------
// amm_slave_mem
// Avalon-MM burst responder emulating a small word-addressed memory.
// Accepts write/read bursts with byteenables, returns read data RD_LAT cycles
// after each word issue, counts served beats and flags protocol violations.
//
// Optional: define AMM_SLAVE_ERR_INJ_EN to add err_inj_i / err_idx_i; while
// err_inj_i is high, reads of word err_idx_i return byte 0 inverted.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   amm_address_i           byte address (low ADDR_B_W bits ignored)
//   amm_read_i              read request
//   amm_write_i             write beat
//   amm_writedata_i         write data
//   amm_byteenable_i        per-byte write enable
//   amm_burstcount_i        burst length, sampled on first beat
//   amm_waitrequest_o       stall (high while issuing a read burst)
//   amm_readdata_o          read data
//   amm_readdatavalid_o     read data valid
//   wr_words_o              accepted write beats (wrapping)
//   rd_words_o              returned read words (wrapping)
//   proto_err_o             sticky protocol-violation flag
//   err_inj_i, err_idx_i    (AMM_SLAVE_ERR_INJ_EN only) error injection
// -----------------------------------------------------------------------------
module amm_slave_mem
    import amm_slave_mem_pkg::*;
#(
    parameter int AMM_ADDR_W  = SLAVE_AMM_ADDR_W,
    parameter int AMM_DATA_W  = SLAVE_AMM_DATA_W,
    parameter int AMM_BURST_W = SLAVE_AMM_BURST_W,
    parameter int MEM_WORDS_W = SLAVE_MEM_WORDS_W,
    parameter int RD_LAT      = SLAVE_RD_LAT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
`ifdef AMM_SLAVE_ERR_INJ_EN
    input  logic                    err_inj_i,
    input  logic [MEM_WORDS_W-1:0]  err_idx_i,
`endif
    input  logic [AMM_ADDR_W-1:0]   amm_address_i,
    input  logic                    amm_read_i,
    input  logic                    amm_write_i,
    input  logic [AMM_DATA_W-1:0]   amm_writedata_i,
    input  logic [AMM_DATA_W/8-1:0] amm_byteenable_i,
    input  logic [AMM_BURST_W-1:0]  amm_burstcount_i,
    output logic                    amm_waitrequest_o,
    output logic [AMM_DATA_W-1:0]   amm_readdata_o,
    output logic                    amm_readdatavalid_o,
    output logic [31:0]             wr_words_o,
    output logic [31:0]             rd_words_o,
    output logic                    proto_err_o
);

    localparam int DATA_B_W = AMM_DATA_W / 8;
    localparam int ADDR_B_W = $clog2(DATA_B_W);

    slave_state_t             r_state;
    logic [MEM_WORDS_W-1:0]   r_idx;
    logic [AMM_BURST_W-1:0]   r_rem;
    logic [31:0]              r_wr_words;
    logic [31:0]              r_rd_words;
    logic                     r_proto_err;

    logic [MEM_WORDS_W-1:0]   w_first_idx;
    logic                     w_bc_zero;
    logic [AMM_BURST_W-1:0]   w_wr_rem_init;
    logic [AMM_BURST_W-1:0]   w_rd_rem_init;
    logic                     w_last;
    logic                     w_wr_en;
    logic [MEM_WORDS_W-1:0]   w_wr_idx;
    logic                     w_rd_en;
    logic                     w_rd_inv0;
    logic                     w_rd_valid;
    logic                     w_unused_addr;

    assign w_first_idx   = amm_address_i[ADDR_B_W+MEM_WORDS_W-1 : ADDR_B_W];
    assign w_unused_addr = ^{amm_address_i[ADDR_B_W-1:0],
                             amm_address_i[AMM_ADDR_W-1 : ADDR_B_W+MEM_WORDS_W]};

    // A zero burstcount is served as a single-word burst.
    assign w_bc_zero     = (amm_burstcount_i == '0);
    assign w_wr_rem_init = w_bc_zero ? '0 : amm_burstcount_i - 1'b1;
    assign w_rd_rem_init = w_bc_zero ? AMM_BURST_W'(1) : amm_burstcount_i;
    assign w_last        = (r_rem == AMM_BURST_W'(1));

    assign amm_waitrequest_o = (r_state == RD_BURST);

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_idx;
        w_rd_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (amm_write_i) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_first_idx;
                end
            end
            WR_BURST: begin
                w_wr_en = amm_write_i;
            end
            RD_BURST: begin
                w_rd_en = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef AMM_SLAVE_ERR_INJ_EN
    assign w_rd_inv0 = err_inj_i && (r_idx == err_idx_i);
`else
    assign w_rd_inv0 = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Write wins over a simultaneous read; the read is dropped.
                    if (amm_write_i) begin
                        r_idx <= w_first_idx + 1'b1;
                        r_rem <= w_wr_rem_init;
                        r_state <= (w_wr_rem_init == '0) ? IDLE : WR_BURST;
                        if (amm_read_i || w_bc_zero) begin
                            r_proto_err <= 1'b1;
                        end
                    end else if (amm_read_i) begin
                        r_idx   <= w_first_idx;
                        r_rem   <= w_rd_rem_init;
                        r_state <= RD_BURST;
                        if (w_bc_zero) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (amm_read_i) begin
                        r_proto_err <= 1'b1;
                    end
                    if (amm_write_i) begin
                        r_idx <= r_idx + 1'b1;
                        r_rem <= r_rem - 1'b1;
                        if (w_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    r_idx <= r_idx + 1'b1;
                    r_rem <= r_rem - 1'b1;
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_words <= '0;
            r_rd_words <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_words <= r_wr_words + 32'd1;
            end
            if (w_rd_valid) begin
                r_rd_words <= r_rd_words + 32'd1;
            end
        end
    end

    amm_slave_ram #(
        .DATA_W  (AMM_DATA_W),
        .WORDS_W (MEM_WORDS_W),
        .RD_LAT  (RD_LAT)
    ) u_ram (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_data  (amm_writedata_i),
        .i_wr_be    (amm_byteenable_i),
        .i_rd_en    (w_rd_en),
        .i_rd_idx   (r_idx),
        .i_rd_inv0  (w_rd_inv0),
        .o_rd_data  (amm_readdata_o),
        .o_rd_valid (w_rd_valid)
    );

    assign amm_readdatavalid_o = w_rd_valid;
    assign wr_words_o          = r_wr_words;
    assign rd_words_o          = r_rd_words;
    assign proto_err_o         = r_proto_err;

endmodule

// File: tb/tb_amm_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_amm_slave_mem
// Self-checking bench for amm_slave_mem: a table of write/read bursts with
// hand-computed data, plus directed sequences for backpressure, protocol
// errors, reset mid-burst and (AMM_SLAVE_ERR_INJ_EN) error injection.
// -----------------------------------------------------------------------------
module tb_amm_slave_mem;

    localparam int AW     = 32;
    localparam int DW     = 512;
    localparam int BW     = 11;
    localparam int MW     = 8;
    localparam int RD_LAT = 2;
    localparam int NB     = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   address = '0;
    logic            read = 1'b0;
    logic            write = 1'b0;
    logic [DW-1:0]   writedata = '0;
    logic [NB-1:0]   byteenable = '0;
    logic [BW-1:0]   burstcount = '0;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;
    logic [31:0]     wr_words;
    logic [31:0]     rd_words;
    logic            proto_err;
`ifdef AMM_SLAVE_ERR_INJ_EN
    logic            err_inj = 1'b0;
    logic [MW-1:0]   err_idx = '0;
`endif

    always #5 clk = ~clk;

    amm_slave_mem #(
        .AMM_ADDR_W  (AW),
        .AMM_DATA_W  (DW),
        .AMM_BURST_W (BW),
        .MEM_WORDS_W (MW),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
`ifdef AMM_SLAVE_ERR_INJ_EN
        .err_inj_i           (err_inj),
        .err_idx_i           (err_idx),
`endif
        .amm_address_i       (address),
        .amm_read_i          (read),
        .amm_write_i         (write),
        .amm_writedata_i     (writedata),
        .amm_byteenable_i    (byteenable),
        .amm_burstcount_i    (burstcount),
        .amm_waitrequest_o   (waitrequest),
        .amm_readdata_o      (readdata),
        .amm_readdatavalid_o (readdatavalid),
        .wr_words_o          (wr_words),
        .rd_words_o          (rd_words),
        .proto_err_o         (proto_err)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // Read-data monitor: every valid word with the cycle it appeared in.
    logic [DW-1:0] rq[$];
    int unsigned   rc[$];
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            rq.push_back(readdata);
            rc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int unsigned exp_wr = 0;
    int unsigned exp_rd = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        rq.delete();
        rc.delete();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 64 && waitrequest === 1'b1; k++) tick();
        chk("wait_ready", waitrequest, 0);
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int n, input logic [7:0] d,
                            input logic [NB-1:0] be);
        wait_ready();
        for (int b = 0; b < n; b++) begin
            write      = 1'b1;
            address    = a;
            writedata  = {NB{d}};
            byteenable = be;
            burstcount = BW'(n);
            tick();
        end
        write = 1'b0;
        exp_wr += n;
    endtask

    task automatic rd_burst(input string nm, input logic [AW-1:0] a, input int n,
                            input logic [DW-1:0] exp);
        int unsigned t0;
        wait_ready();
        rq.delete();
        rc.delete();
        read       = 1'b1;
        address    = a;
        burstcount = BW'(n);
        tick();
        read = 1'b0;
        t0   = cyc;
        for (int k = 0; k < n + RD_LAT + 16 && rq.size() < n; k++) tick();
        chk({nm, "_count"}, rq.size(), n);
        for (int k = 0; k < n && k < rq.size(); k++) begin
            chk($sformatf("%s_data%0d", nm, k), rq[k], exp);
            chk($sformatf("%s_cycle%0d", nm, k), rc[k], t0 + RD_LAT + k);
        end
        exp_rd += n;
        chk({nm, "_rd_words"}, rd_words, exp_rd);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        int            n;
        logic [7:0]    dat;
        logic [NB-1:0] be;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tv[10];

    initial begin : main
        int unsigned t0;
        int unsigned t_r;
        int cnt;
        int late;

        tv[0] = '{1'b1, 32'h0000_0040, 4, 8'hA5, '1, '0};
        tv[1] = '{1'b0, 32'h0000_0040, 4, 8'h00, '0, {NB{8'hA5}}};
        tv[2] = '{1'b1, 32'h0000_00C0, 1, 8'hFF, '1, '0};
        tv[3] = '{1'b1, 32'h0000_00C0, 1, 8'h11, NB'(4'hF), '0};
        tv[4] = '{1'b0, 32'h0000_00C0, 1, 8'h00, '0, {{(NB-4){8'hFF}}, {4{8'h11}}}};
        tv[5] = '{1'b1, 32'h0000_3FC0, 3, 8'h3C, '1, '0};
        tv[6] = '{1'b0, 32'h0000_3FC0, 3, 8'h00, '0, {NB{8'h3C}}};
        tv[7] = '{1'b0, 32'h0000_0000, 2, 8'h00, '0, {NB{8'h3C}}};
        tv[8] = '{1'b0, 32'h0000_0080, 1, 8'h00, '0, {NB{8'hA5}}};
        tv[9] = '{1'b0, 32'hABCD_0043, 1, 8'h00, '0, {NB{8'h3C}}};

        do_reset();
        chk("rst_waitrequest", waitrequest, 0);
        chk("rst_rdvalid", readdatavalid, 0);
        chk("rst_readdata", readdata, '0);
        chk("rst_wr_words", wr_words, 0);
        chk("rst_rd_words", rd_words, 0);
        chk("rst_proto_err", proto_err, 0);

        for (int i = 0; i < 10; i++) begin
            if (tv[i].wr) begin
                wr_burst(tv[i].addr, tv[i].n, tv[i].dat, tv[i].be);
                chk($sformatf("v%0d_wr_words", i), wr_words, exp_wr);
            end else begin
                rd_burst($sformatf("v%0d", i), tv[i].addr, tv[i].n, tv[i].exp);
            end
            chk($sformatf("v%0d_proto_err", i), proto_err, 0);
        end

        // Read burst of 8 while the master holds a write request.
        wait_ready();
        rq.delete();
        rc.delete();
        read       = 1'b1;
        address    = '0;
        burstcount = BW'(8);
        tick();
        read       = 1'b0;
        t0         = cyc;
        write      = 1'b1;
        address    = 32'(10 * NB);
        writedata  = {NB{8'h77}};
        byteenable = '1;
        burstcount = BW'(1);
        cnt = 0;
        while (waitrequest === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("bp_wait_cycles", cnt, 8);
        chk("bp_wr_held", wr_words, exp_wr);
        tick();
        write = 1'b0;
        exp_wr++;
        chk("bp_wr_accepted", wr_words, exp_wr);
        for (int k = 0; k < 32 && rq.size() < 8; k++) tick();
        chk("bp_rd_count", rq.size(), 8);
        if (rq.size() == 8) begin
            chk("bp_first_cycle", rc[0], t0 + RD_LAT);
            chk("bp_last_cycle", rc[7], t0 + RD_LAT + 7);
        end
        exp_rd += 8;
        chk("bp_rd_words", rd_words, exp_rd);
        chk("bp_proto_err", proto_err, 0);
        rd_burst("bp_readback", 32'(10 * NB), 1, {NB{8'h77}});

        // Read and write together in IDLE: write wins, error flagged.
        do_reset();
        read       = 1'b1;
        write      = 1'b1;
        address    = 32'(20 * NB);
        writedata  = {NB{8'h42}};
        byteenable = '1;
        burstcount = BW'(1);
        tick();
        read  = 1'b0;
        write = 1'b0;
        chk("rw_proto_err", proto_err, 1);
        chk("rw_wr_words", wr_words, 1);
        chk("rw_waitrequest", waitrequest, 0);
        repeat (4) tick();
        chk("rw_no_read", rd_words, 0);

        // Burstcount 0 is served as one word and flagged.
        do_reset();
        write      = 1'b1;
        address    = 32'(21 * NB);
        writedata  = {NB{8'h5A}};
        byteenable = '1;
        burstcount = '0;
        tick();
        write = 1'b0;
        exp_wr = 1;
        chk("bc0_proto_err", proto_err, 1);
        chk("bc0_wr_words", wr_words, 1);
        rd_burst("bc0_readback", 32'(21 * NB), 1, {NB{8'h5A}});

        // Read during a write burst is ignored and flagged.
        do_reset();
        write      = 1'b1;
        address    = 32'(30 * NB);
        writedata  = {NB{8'h0F}};
        byteenable = '1;
        burstcount = BW'(2);
        tick();
        write = 1'b0;
        read  = 1'b1;
        tick();
        read = 1'b0;
        chk("wrb_read_err", proto_err, 1);
        write = 1'b1;
        tick();
        write = 1'b0;
        chk("wrb_wr_words", wr_words, 2);
        chk("wrb_no_read", rd_words, 0);

        // Reset during the third issue of a 16-word read.
        do_reset();
        read       = 1'b1;
        address    = '0;
        burstcount = BW'(16);
        tick();
        read = 1'b0;
        t0   = cyc;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t_r = cyc;
        repeat (8) tick();
        late = 0;
        foreach (rc[k]) if (rc[k] >= t_r) late++;
        chk("mid_rst_no_valid", late, 0);
        chk("mid_rst_issue_seen", t_r, t0 + 3);
        chk("mid_rst_waitrequest", waitrequest, 0);
        chk("mid_rst_wr_words", wr_words, 0);
        chk("mid_rst_rd_words", rd_words, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        exp_wr = 0;
        exp_rd = 0;
        rd_burst("mid_rst_kept", 32'h0000_0040, 1, {NB{8'h3C}});

`ifdef AMM_SLAVE_ERR_INJ_EN
        err_inj = 1'b1;
        err_idx = MW'(5);
        wr_burst(32'(5 * NB), 1, 8'h00, '1);
        rd_burst("inj_hit", 32'(5 * NB), 1, {{(NB-1){8'h00}}, 8'hFF});
        rd_burst("inj_miss", 32'h0000_0040, 1, {NB{8'h3C}});
        err_inj = 1'b0;
        rd_burst("inj_off", 32'(5 * NB), 1, '0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
